// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA object path.
package vga_pkg;

  typedef logic [7:0] rgb_t;

  localparam rgb_t        TRANSPARENT_RGB = 8'hFF;
  localparam rgb_t        BLACK_RGB       = 8'h00;
  localparam int unsigned MAX_LAYERS      = 8;
  localparam int unsigned SEL_W           = 3;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } report_state_e;

endpackage

// File: rtl/objects_compositor_if.sv
// Pixel, frame and collision-report signals between the bitmap path and the compositor.
interface objects_compositor_if #(
  parameter int unsigned NUM_LAYERS = 4
);
  import vga_pkg::*;

  logic [NUM_LAYERS-1:0] drawReq;
  rgb_t [NUM_LAYERS-1:0] layerRGB;
  logic                  visible;
  logic                  startOfFrame;
  rgb_t                  RGBOut;
  logic [NUM_LAYERS-1:0] collPulse;
  logic [NUM_LAYERS-1:0] reportMask;
  logic                  reportValid;
  logic                  reportReady;
  logic                  reportOverrun;

  modport master (
    output drawReq, layerRGB, visible, startOfFrame, reportReady,
    input  RGBOut, collPulse, reportMask, reportValid, reportOverrun
  );

  modport slave (
    input  drawReq, layerRGB, visible, startOfFrame, reportReady,
    output RGBOut, collPulse, reportMask, reportValid, reportOverrun
  );

endinterface

// File: rtl/layer_priority_encoder.sv
// Picks the highest-priority (lowest index) drawing layer and flags overlaps.
module layer_priority_encoder
  import vga_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0] drawReq,
  output logic [SEL_W-1:0]      sel,
  output logic                  any,
  output logic                  overlap
);

  always_comb begin
    sel = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (drawReq[i]) sel = SEL_W'(i);
    end
  end

  assign any = |drawReq;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign overlap = |(drawReq & (drawReq - {{(NUM_LAYERS-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/objects_compositor.sv
// Per-pixel priority compositor with per-frame collision tracking and a
// valid/ready frame collision report.
module objects_compositor
  import vga_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter rgb_t        BG_RGB     = 8'h00
) (
  input logic                  clk,
  input logic                  reset,
  objects_compositor_if.slave  bus
);

  logic [SEL_W-1:0]      sel;
  logic                  any;
  logic                  overlap;
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] fmask_d, fmask_q;
  logic [NUM_LAYERS-1:0] pulse_d, pulse_q;
  logic [NUM_LAYERS-1:0] mask_q;
  logic                  valid_q;
  logic                  ovr_q;
  rgb_t                  rgb_d, rgb_q;
  report_state_e         state_q;

  layer_priority_encoder #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_enc (
    .drawReq (bus.drawReq),
    .sel     (sel),
    .any     (any),
    .overlap (overlap)
  );

  always_comb begin
    rgb_d = BG_RGB;
    if (!bus.visible) begin
      rgb_d = BLACK_RGB;
    end else if (any) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (sel == SEL_W'(i)) rgb_d = bus.layerRGB[i];
      end
    end
  end

  // On a frame start the old mask is dropped, so this cycle's hits always pulse.
  always_comb begin
    hit     = (overlap && bus.visible) ? bus.drawReq : '0;
    pulse_d = hit & (~fmask_q | {NUM_LAYERS{bus.startOfFrame}});
    fmask_d = bus.startOfFrame ? hit : (fmask_q | hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= BLACK_RGB;
      pulse_q <= '0;
      fmask_q <= '0;
    end else begin
      rgb_q   <= rgb_d;
      pulse_q <= pulse_d;
      fmask_q <= fmask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      mask_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (bus.startOfFrame) begin
            state_q <= StFull;
            mask_q  <= fmask_q;
            valid_q <= 1'b1;
          end
        end
        StFull: begin
          if (bus.startOfFrame) begin
            // A same-cycle transfer frees the slot, so the new snapshot replaces it.
            if (bus.reportReady) begin
              mask_q <= fmask_q;
            end else begin
              mask_q <= mask_q | fmask_q;
              ovr_q  <= 1'b1;
            end
          end else if (bus.reportReady) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.RGBOut        = rgb_q;
  assign bus.collPulse     = pulse_q;
  assign bus.reportMask    = mask_q;
  assign bus.reportValid   = valid_q;
  assign bus.reportOverrun = ovr_q;

endmodule
